// File: rtl/nibble_max_scheduler.sv
// rtl/nibble_max_scheduler.sv - running-max sequencer over a shared pipelined nibble comparator
// Optional feature macro: NIBBLE_MAX_INDEX_EN adds the max_idx output and its shadow register.
module nibble_max_scheduler #(
  parameter int N_WORDS = 8,
  parameter int CMP_LAT = 5,
  localparam int IDX_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
  localparam int WAIT_W = $clog2(CMP_LAT + 1),
  localparam int BUF_N  = (N_WORDS > 1) ? N_WORDS : 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  output logic [3:0]       cmp_a,
  output logic [3:0]       cmp_b,
  input  logic [3:0]       cmp_mayor,
  output logic             busy,
  output logic             done,
  output logic [3:0]       max_out
`ifdef NIBBLE_MAX_INDEX_EN
  ,
  output logic [IDX_W-1:0] max_idx
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CMP, S_FIN} state_t;

  state_t              state_q;
  state_t              state_d;
  logic [3:0]          data_buf [BUF_N];
  logic [IDX_W-1:0]    wr_ptr;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_inc;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [3:0]          run_max;
  logic                accept;
  logic                last_accept;
  logic                capture;
  logic                last_capture;
`ifdef NIBBLE_MAX_INDEX_EN
  logic [IDX_W-1:0]    best_idx;
`endif

  assign idx_inc = idx + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus the handshake and capture strobes the datapath keys off.
  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    busy         = (state_q != S_IDLE);
    accept       = 1'b0;
    last_accept  = 1'b0;
    capture      = 1'b0;
    last_capture = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (wr_ptr == IDX_W'(N_WORDS - 1)) begin
            last_accept = 1'b1;
            state_d     = (N_WORDS == 1) ? S_FIN : S_CMP;
          end
        end
      end
      S_CMP: begin
        // Comparator output is only trusted once the full latency has elapsed.
        if (wait_cnt == WAIT_W'(CMP_LAT)) begin
          capture = 1'b1;
          if (idx == IDX_W'(N_WORDS - 1)) begin
            last_capture = 1'b1;
            state_d      = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Burst buffer; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (accept) data_buf[wr_ptr] <= in_data;
  end

  // Operand sequencing, running max and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      run_max  <= '0;
      cmp_a    <= '0;
      cmp_b    <= '0;
      done     <= 1'b0;
      max_out  <= '0;
`ifdef NIBBLE_MAX_INDEX_EN
      best_idx <= '0;
      max_idx  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: if (start) wr_ptr <= '0;
        S_LOAD: begin
          if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (last_accept) begin
              wait_cnt <= '0;
              idx      <= IDX_W'(1);
`ifdef NIBBLE_MAX_INDEX_EN
              best_idx <= '0;
`endif
              if (N_WORDS == 1) begin
                run_max <= in_data;
              end else begin
                // Element 1 is still in flight on in_data when the burst is two long.
                run_max <= data_buf[0];
                cmp_a   <= data_buf[0];
                cmp_b   <= (N_WORDS == 2) ? in_data : data_buf[1];
              end
            end
          end
        end
        S_CMP: begin
          if (capture) begin
            run_max  <= cmp_mayor;
            cmp_a    <= cmp_mayor;
            wait_cnt <= '0;
            idx      <= idx_inc;
            if (!last_capture) cmp_b <= data_buf[idx_inc];
`ifdef NIBBLE_MAX_INDEX_EN
            // A result differing from the running max means the candidate won; ties keep the older index.
            if (cmp_mayor != run_max) best_idx <= idx;
`endif
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_FIN: begin
          done    <= 1'b1;
          max_out <= run_max;
`ifdef NIBBLE_MAX_INDEX_EN
          max_idx <= best_idx;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_max_scheduler.sv
// tb/tb_nibble_max_scheduler.sv - scoreboard bench for nibble_max_scheduler (default and single-word builds)
module tb_nibble_max_scheduler;

  localparam int NW       = 8;
  localparam int LAT      = 5;
  localparam int DONE_LAT = (NW - 1) * (LAT + 1) + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, in_valid;
  logic [3:0] in_data;
  logic       in_ready, busy, done;
  logic [3:0] cmp_a, cmp_b, cmp_mayor, max_out;
  logic       start1, in_valid1;
  logic [3:0] in_data1;
  logic       in_ready1, busy1, done1;
  logic [3:0] cmp_a1, cmp_b1, max_out1;
`ifdef NIBBLE_MAX_INDEX_EN
  logic [2:0] max_idx;
  logic [0:0] max_idx1;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ndone = 0;
  bit desc_chk = 1'b0;
  int exp_max_q[$];
  int exp_idx_q[$];
  int exp_cyc_q[$];

  // Comparator model: true max only after operands have been stable LAT edges, noise before that.
  logic [3:0] last_a = 4'h0;
  logic [3:0] last_b = 4'h0;
  logic [3:0] garbage = 4'h0;
  int         stable_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    garbage <= 4'($urandom);
    if (cmp_a != last_a || cmp_b != last_b) stable_cnt <= 1;
    else if (stable_cnt < 1000)             stable_cnt <= stable_cnt + 1;
    last_a <= cmp_a;
    last_b <= cmp_b;
  end

  assign cmp_mayor = (stable_cnt >= LAT) ? ((cmp_a > cmp_b) ? cmp_a : cmp_b) : garbage;

  nibble_max_scheduler #(.N_WORDS(NW), .CMP_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_mayor(cmp_mayor),
    .busy(busy), .done(done), .max_out(max_out)
`ifdef NIBBLE_MAX_INDEX_EN
    , .max_idx(max_idx)
`endif
  );

  nibble_max_scheduler #(.N_WORDS(1), .CMP_LAT(LAT)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .cmp_a(cmp_a1), .cmp_b(cmp_b1), .cmp_mayor(4'h0),
    .busy(busy1), .done(done1), .max_out(max_out1)
`ifdef NIBBLE_MAX_INDEX_EN
    , .max_idx(max_idx1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drives one burst (nibble i at data[4*i+:4]); expectations are queued at the final accept.
  task automatic send_job(input logic [31:0] data, input int stall_at, input bit hold_valid,
                          input bit expect_done);
    logic [3:0] mx;
    int         mi;
    mx = data[3:0];
    mi = 0;
    for (int i = 1; i < NW; i++) begin
      if (data[4*i +: 4] > mx) begin
        mx = data[4*i +: 4];
        mi = i;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (i == stall_at) begin
        in_valid = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("in_ready_stall", in_ready, 1);
        end
      end
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = data[4*i +: 4];
      if (i == NW - 1 && expect_done) begin
        exp_max_q.push_back(int'(mx));
        exp_idx_q.push_back(mi);
        exp_cyc_q.push_back(cyc + 1 + DONE_LAT);
      end
      @(negedge clk);
    end
    if (hold_valid) in_data = 4'hF;
    else            in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_max_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_max_q.size() != 0) begin
      chk("done_timeout", 0, 1);
      exp_max_q.delete();
      exp_idx_q.delete();
      exp_cyc_q.delete();
    end
    @(negedge clk);
  endtask

  // Output monitor: every done pops one expected result.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        ndone++;
        if (exp_max_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          chk("max_out", max_out, exp_max_q.pop_front());
          chk("done_cycle", cyc, exp_cyc_q.pop_front());
`ifdef NIBBLE_MAX_INDEX_EN
          chk("max_idx", max_idx, exp_idx_q.pop_front());
`else
          void'(exp_idx_q.pop_front());
`endif
        end
      end
      if (desc_chk && busy && !in_ready) chk("cmp_a_desc", cmp_a, 4'hF);
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'h0;
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_max_out", max_out, 0);
    chk("rst_cmp_ab", {cmp_a, cmp_b}, 0);
    chk("rst1_busy", busy1, 0);
`ifdef NIBBLE_MAX_INDEX_EN
    chk("rst_max_idx", max_idx, 0);
`endif
    reset = 1'b0;

    send_job(32'h701FF293, -1, 1'b0, 1'b1);
    wait_drain();

    send_job(32'h00000000, 4, 1'b0, 1'b1);
    wait_drain();

    // start pulses during CMP and in_valid held high through CMP and IDLE
    send_job(32'h6218C3C5, -1, 1'b1, 1'b1);
    repeat (3) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_drain();
    repeat (5) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    // abort mid-CMP
    send_job(32'h55555555, -1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_max_out", max_out, 0);
    chk("abort_done", done, 0);
    reset = 1'b0;
    repeat (60) @(negedge clk);

    send_job(32'h87654321, -1, 1'b0, 1'b1);
    wait_drain();

    desc_chk = 1'b1;
    send_job(32'h89ABCDEF, -1, 1'b0, 1'b1);
    wait_drain();
    desc_chk = 1'b0;

    chk("done_count", ndone, 5);

    // single-word build
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("n1_in_ready", in_ready1, 1);
    in_valid1 = 1'b1;
    in_data1  = 4'hA;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("n1_done_early", done1, 0);
    chk("n1_busy_fin", busy1, 1);
    @(negedge clk);
    chk("n1_done", done1, 1);
    chk("n1_max_out", max_out1, 4'hA);
    chk("n1_cmp_ab", {cmp_a1, cmp_b1}, 0);
`ifdef NIBBLE_MAX_INDEX_EN
    chk("n1_max_idx", max_idx1, 0);
`endif
    @(negedge clk);
    chk("n1_done_pulse", done1, 0);
    chk("n1_busy_idle", busy1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
